// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port plus the valid/ready output stream.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12
);
  logic                  mem_read_req;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  modport master (
    output mem_read_req, mem_read_addr, m_data, m_valid,
    input  mem_read_data, m_ready
  );
  modport slave (
    input  mem_read_req, mem_read_addr, m_data, m_valid,
    output mem_read_data, m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams num_words RAM words from base_addr with credit-limited reads.
module ram_stream_reader #(
  parameter int DATA_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  ram_stream_reader_if.master   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic [CW-1:0]           inflight, count;
  logic [READ_LATENCY-1:0] sr;
  logic [DATA_WIDTH-1:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0]           wr, rd;
  logic                    req, push, pop, drained;
  assign push    = sr[READ_LATENCY-1];
  assign pop     = bus.m_valid && bus.m_ready;
  assign drained = inflight == '0 && count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE && start) ? (num_words == '0 ? DRAIN : RUN)
             : (state == RUN && remaining == '0) ? DRAIN
             : (state == DRAIN && drained) ? IDLE
             : state;
  end
  // Credits cover both words in flight and words already buffered, so the FIFO cannot overflow.
  always_comb begin
    busy = state != IDLE;
    done = state == DRAIN && drained;
    req  = state == RUN && remaining != '0 &&
           ((CW+1)'(inflight) + (CW+1)'(count)) < (CW+1)'(FIFO_DEPTH);
  end
  assign bus.mem_read_req  = req;
  assign bus.mem_read_addr = addr;
  assign bus.m_valid       = count != '0;
  assign bus.m_data        = bus.m_valid ? fifo[rd] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= '0;
      count     <= '0;
      sr        <= '0;
      wr        <= '0;
      rd        <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= num_words;
      end else if (req) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      sr       <= READ_LATENCY'({sr, req});
      inflight <= inflight + CW'(req) - CW'(push);
      count    <= count + CW'(push) - CW'(pop);
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) fifo[wr] <= bus.mem_read_data;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench with a two-stage registered RAM model.
module tb_ram_stream_reader;
  logic        clk = 0, reset = 1, start = 0;
  logic [11:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic        busy, done;
  ram_stream_reader_if b ();
  ram_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .bus(b)
  );
  always #5 clk = ~clk;
  logic [9:0] mem [4096];
  logic [9:0] r1 = '0, r2 = '0;
  initial for (int a = 0; a < 4096; a++) mem[a] = a[9:0];
  always @(posedge clk) begin
    if (b.mem_read_req) r1 <= mem[b.mem_read_addr];
    r2 <= r1;
  end
  assign b.mem_read_data = r2;
  int checks = 0, errors = 0, cyc = 0;
  int first_req, first_valid, first_pop, last_pop, done_cyc;
  int ndone = 0, nreq = 0, nbusy = 0, out = 0, maxout = 0, ph = 0;
  bit toggle = 0;
  logic [11:0] aq [$];
  logic [9:0]  dq [$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!reset) out = 0;
    else begin
      if (busy) nbusy++;
      if (done) begin ndone++; done_cyc = cyc; end
      if (b.m_valid && first_valid < 0) first_valid = cyc;
      if (b.mem_read_req) begin
        nreq++;
        out++;
        if (first_req < 0) first_req = cyc;
        if (out > maxout) maxout = out;
        check("credit", 32'(out <= 4), 1);
        if (aq.size() == 0) check("addr_extra", 1, 0);
        else check("addr", 32'(b.mem_read_addr), 32'(aq.pop_front()));
      end
      if (b.m_valid && b.m_ready) begin
        out--;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (dq.size() == 0) check("data_extra", 1, 0);
        else check("data", 32'(b.m_data), 32'(dq.pop_front()));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (toggle) begin
      b.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
    end
  endtask
  task automatic run_xfer(input logic [11:0] base, input int n, input bit intrude);
    logic [11:0] a;
    first_req = -1; first_valid = -1; first_pop = -1; last_pop = -1; done_cyc = -1;
    ndone = 0; nreq = 0; nbusy = 0; maxout = 0; ph = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      aq.push_back(a);
      dq.push_back(a[9:0]);
    end
    start = 1; base_addr = base; num_words = 13'(n);
    step();
    start = 0;
    for (int i = 0; i < 300 && ndone == 0; i++) begin
      if (intrude && i == 2) begin start = 1; base_addr = 12'h100; num_words = 13'd3; end
      step();
      start = 0;
    end
    check("done_seen", 32'(ndone), 1);
    step();
    check("done_count", 32'(ndone), 1);
    check("addr_left", 32'(aq.size()), 0);
    check("data_left", 32'(dq.size()), 0);
  endtask
  initial begin
    b.m_ready = 1;
    #1 reset = 0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(b.mem_read_req), 0);
    check("rst_addr", 32'(b.mem_read_addr), 0);
    check("rst_valid", 32'(b.m_valid), 0);
    check("rst_data", 32'(b.m_data), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step();
    run_xfer(12'h010, 8, 0);
    check("latency", 32'(first_valid - first_req), 3);
    check("throughput", 32'(last_pop - first_pop), 7);
    check("done_timing", 32'(done_cyc - last_pop), 1);
    check("nreq", 32'(nreq), 8);
    toggle = 1;
    run_xfer(12'h010, 8, 0);
    check("max_credit", 32'(maxout), 4);
    toggle = 0;
    b.m_ready = 1;
    run_xfer(12'hFFE, 4, 0);
    run_xfer(12'h000, 0, 0);
    check("zero_reqs", 32'(nreq), 0);
    check("zero_busy", 32'(nbusy), 1);
    check("zero_valid", 32'(first_valid), 32'hFFFF_FFFF);
    run_xfer(12'h040, 5, 1);
    check("intrude_reqs", 32'(nreq), 5);
    b.m_ready = 0;
    for (int i = 0; i < 8; i++) begin aq.push_back(12'h020 + 12'(i)); dq.push_back(10'h020 + 10'(i)); end
    start = 1; base_addr = 12'h020; num_words = 13'd8;
    step();
    start = 0;
    for (int i = 0; i < 20 && !b.m_valid; i++) step();
    check("pre_rst_valid", 32'(b.m_valid), 1);
    #2 reset = 0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_req", 32'(b.mem_read_req), 0);
    check("mid_rst_addr", 32'(b.mem_read_addr), 0);
    check("mid_rst_valid", 32'(b.m_valid), 0);
    check("mid_rst_data", 32'(b.m_data), 0);
    @(posedge clk);
    #1 reset = 1;
    aq.delete();
    dq.delete();
    b.m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("stale_valid", 32'(b.m_valid), 0);
    end
    run_xfer(12'h030, 2, 0);
    check("post_rst_reqs", 32'(nreq), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the team's registered dual-port RAM primitive. Drives that RAM's read port: request, address, and returned data READ_LATENCY cycles later.
- On a start pulse, reads num_words consecutive words beginning at base_addr. Presents them on a valid/ready stream to downstream compute.
- Credit-based flow control plus an internal FIFO, so back-pressure never loses in-flight read data.

Parameters:
- DATA_WIDTH, 10, word width; matches RAM DATA_WIDTH.
- ADDR_WIDTH, 12, RAM address width.
- READ_LATENCY, 2, cycles from mem_read_req high to mem_read_data valid; fixed by the RAM.
- FIFO_DEPTH, 4, output buffer entries; must be ≥ READ_LATENCY+2 and a power of two.

Ports:
- clk  in  1  Clock; all logic is rising-edge.
- reset  in  1  Asynchronous, active-low reset. The port keeps the codebase name "reset"; 0 resets.
- start  in  1  One-cycle pulse that begins a transfer; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  First address; sampled when start is accepted.
- num_words  in  ADDR_WIDTH+1  Word count, 0..2^ADDR_WIDTH; sampled with start.
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse when the transfer completes.
- mem_read_req  out  1  RAM read request.
- mem_read_addr  out  ADDR_WIDTH  RAM read address.
- mem_read_data  in  DATA_WIDTH  RAM read data.
- m_data  out  DATA_WIDTH  Stream data; equals FIFO head.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready.

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, mem_read_req, m_valid = 0. mem_read_addr, m_data = 0. All counters, FIFO pointers and the latency shift register are cleared. Reset mid-transfer abandons the transfer; stale RAM data arriving after reset release is discarded because the shift register is cleared.
- FSM states IDLE, RUN, DRAIN.
  - IDLE: start=1 → load addr=base_addr, remaining=num_words. If num_words=0, go to DRAIN (done fires next cycle, no reads). Otherwise go to RUN.
  - RUN: issue reads until remaining=0, then go to DRAIN.
  - DRAIN: wait until in-flight count=0, FIFO is empty and the last word has been accepted. Then pulse done for 1 cycle and return to IDLE.
- busy=1 whenever state≠IDLE.
- Issue rule (combinational): mem_read_req = (state==RUN) && remaining≠0 && (inflight + fifo_count) < FIFO_DEPTH.
  - mem_read_addr = current addr.
  - Each issued request: addr increments modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000), remaining decrements, inflight increments.
- Return path: a READ_LATENCY-deep shift register of request flags marks which cycles carry valid mem_read_data.
  - When the flag exits the register, mem_read_data is written into the FIFO at that clock edge and inflight decrements.
  - Data arriving when no flag is set is never captured; the RAM holds stale data then.
- Output: m_valid = fifo_count≠0; m_data = FIFO head. A pop occurs on m_valid && m_ready.
- Simultaneous push and pop in one cycle is legal; fifo_count is unchanged.
- The credit rule guarantees the FIFO never overflows; an overflow is a bench assertion failure.
- Latency: start accepted at edge E0 → first mem_read_req in the cycle after E0 → m_valid high 3 cycles after that first request (RAM latency 2 + FIFO capture 1).
- Throughput with m_ready held high: 1 word/cycle sustained.
- Ordering: words are emitted strictly in address order; no word is dropped or duplicated.
- done asserts the cycle after the final word's pop.
- start may be accepted in the same cycle done is high? No: done is asserted in DRAIN→IDLE transition cycle; start is accepted in the following cycle at the earliest.

Test Plan:
- base_addr=0x010, num_words=8, RAM preloaded mem[a]=a, m_ready=1 → m_data 0x010..0x017 on consecutive cycles; first m_valid 3 cycles after first mem_read_req; done 1 cycle after the last pop.
- Same transfer with m_ready toggled 1,0,0,1 repeating → identical ordered data; inflight+fifo_count never exceeds 4; mem_read_req stalls while credits are exhausted.
- base_addr=0xFFE, num_words=4 → read addresses 0xFFE, 0xFFF, 0x000, 0x001; data emitted in that order.
- num_words=0 → no mem_read_req; busy high 1 cycle; done pulses; m_valid stays 0.
- start asserted again while busy, with different base_addr → ignored; the original transfer completes unchanged.
- reset driven low mid-transfer after 3 requests, 1 word buffered → outputs 0 immediately (async); after release, no m_valid from stale data; a new start with num_words=2 completes normally.
